// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the MEM stage, paging unit and fetch.
// Each grant holds the bus for WAIT_CYCLES plus a bus_ready handshake.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              pg_req,
  input  logic              pg_we,
  input  logic [ADDR_W-1:0] pg_addr,
  input  logic [DATA_W-1:0] pg_wdata,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_re,
  output logic              bus_we,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] pg_rdata,
  output logic              pg_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              mem_pipe_stall,
  output logic              if_stall,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned STV_W = 3;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_MEM, OWN_PG, OWN_IF} owner_t;

  state_t             state;
  owner_t             owner;
  owner_t             grant;
  logic [CNT_W-1:0]   wait_cnt;
  logic [STV_W-1:0]   starve_cnt;
  logic               mem_elig, pg_elig, if_elig, if_promoted;

  // A requester in its done cycle is not eligible, so it cannot be re-granted
  // while it is still dropping its request.
  assign mem_elig    = mem_req & ~mem_done;
  assign pg_elig     = pg_req  & ~pg_done;
  assign if_elig     = if_req  & ~if_done;
  assign if_promoted = (starve_cnt >= STV_W'(STARVE_LIMIT));

  // Fixed priority MEM > PG > IF; a starved fetch jumps ahead of paging.
  always_comb begin
    grant = OWN_NONE;
    if (mem_elig)                  grant = OWN_MEM;
    else if (if_promoted && if_elig) grant = OWN_IF;
    else if (pg_elig)              grant = OWN_PG;
    else if (if_elig)              grant = OWN_IF;
  end

  assign mem_pipe_stall = mem_req & ~mem_done;
  assign if_stall       = if_req  & ~if_done;
  assign busy           = (state == ACCESS);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_re     <= 1'b0;
      bus_we     <= 1'b0;
      mem_rdata  <= '0;
      pg_rdata   <= '0;
      if_rdata   <= '0;
      mem_done   <= 1'b0;
      pg_done    <= 1'b0;
      if_done    <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      pg_done  <= 1'b0;
      if_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != OWN_NONE) begin
            state    <= ACCESS;
            owner    <= grant;
            wait_cnt <= CNT_W'(WAIT_CYCLES);
            case (grant)
              OWN_MEM: begin
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_we    <= mem_we;
                bus_re    <= ~mem_we;
              end
              OWN_PG: begin
                bus_addr  <= pg_addr;
                bus_wdata <= pg_wdata;
                bus_we    <= pg_we;
                bus_re    <= ~pg_we;
              end
              default: begin
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                bus_we    <= 1'b0;
                bus_re    <= 1'b1;
              end
            endcase
            if (grant == OWN_IF)
              starve_cnt <= '0;
            else if (if_elig && (starve_cnt != {STV_W{1'b1}}))
              starve_cnt <= starve_cnt + STV_W'(1);
          end
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end else if (bus_ready) begin
            state  <= IDLE;
            owner  <= OWN_NONE;
            bus_re <= 1'b0;
            bus_we <= 1'b0;
            case (owner)
              OWN_MEM: begin
                mem_done <= 1'b1;
                if (!bus_we) mem_rdata <= bus_rdata;
              end
              OWN_PG: begin
                pg_done <= 1'b1;
                if (!bus_we) pg_rdata <= bus_rdata;
              end
              OWN_IF: begin
                if_done  <= 1'b1;
                if_rdata <= bus_rdata;
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
      // Fetch that is not asking cannot be starving.
      if (!if_req) starve_cnt <= '0;
    end
  end

endmodule
